// File: rtl/mips_dmem_bridge.sv
// mips_dmem_bridge
//   Data-side bridge between the single-cycle MIPS core's lw/sw path and a
//   registered req/ack data-memory bus. The core is stalled while an access
//   is in flight. Misaligned, conflicting (rd and wr together), timed-out and
//   bus-errored accesses return ERR_DATA and set a sticky error flag.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   cpu_rd/cpu_wr  load / store request from the core (held while stalled)
//   cpu_addr       byte address; cpu_wdata store data
//   cpu_rdata      load data, valid in the DONE cycle
//   cpu_stall      core must hold its state while high
//   cpu_err        sticky error flag; err_clr clears it (a new error wins)
//   bus_req/bus_we/bus_addr/bus_wdata   registered bus request (word address)
//   bus_rdata/bus_ack/bus_err           bus response; bus_err qualified by bus_ack
//   dbg_state      current FSM state (IDLE=0, BUS=1, DONE=2)
//
// Handshake: bus_req rises with bus_we/bus_addr/bus_wdata already valid and all
// four hold until the cycle in which bus_ack is sampled high; bus_req drops on
// the following edge. bus_ack outside an outstanding request is ignored.
module mips_dmem_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  input  logic              err_clr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic req_any;
  logic req_bad;
  logic cnt_last;
  logic bus_end;
  logic bus_fail;

  assign req_any  = cpu_rd | cpu_wr;
  assign req_bad  = (cpu_rd & cpu_wr) | (cpu_addr[1:0] != 2'b00);
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
  // An ack always ends the access, even in the cycle the timeout would fire.
  assign bus_end  = bus_ack | cnt_last;
  assign bus_fail = bus_ack ? bus_err : 1'b1;

  assign dbg_state = state;

  // Stall is combinational so the core freezes in the very cycle it issues
  // the request; forced low while reset is held.
  always_comb begin
    cpu_stall = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE:  cpu_stall = req_any;
        S_BUS:   cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      // Clear first; any error set below in the same cycle overrides it.
      if (err_clr) cpu_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_any) begin
            if (req_bad) begin
              cpu_rdata <= ERR_DATA;
              cpu_err   <= 1'b1;
              state     <= S_DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= cpu_wr;
              bus_addr  <= cpu_addr[ADDR_W-1:2];
              bus_wdata <= cpu_wdata;
              cnt       <= '0;
              state     <= S_BUS;
            end
          end
        end

        S_BUS: begin
          if (bus_end) begin
            bus_req <= 1'b0;
            state   <= S_DONE;
            if (bus_fail) begin
              cpu_rdata <= ERR_DATA;
              cpu_err   <= 1'b1;
            end else if (!bus_we) begin
              cpu_rdata <= bus_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // One unstalled cycle lets the core retire the instruction before a
        // new request can be accepted.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
